counter4_pulse_sched: RTL and testbench

//  Sequencer/arbiter in front of the routed 4-bit counter macro: shares its en/rst pads among NREQ requesters.

---
 rtl/counter4_sched_pkg.sv | 36 +++
 rtl/counter4_pulse_sched_rr_arbiter.sv | 81 ++++++++
 rtl/counter4_pulse_sched.sv | 194 +++++++++++++++++++
 tb/tb_counter4_pulse_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter4_sched_pkg.sv
// ---------------------------------------------------------------------------
// counter4_sched_pkg
// Shared types for the counter4 pulse scheduler: request opcodes, FSM states
// and small opcode decode helpers.
//   op_e    : requester opcode (NOP / INC / CLR / CLR_INC)
//   state_e : scheduler FSM state
//   OP_W    : width of one requester's opcode field
// ---------------------------------------------------------------------------
package counter4_sched_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 2'b00,
    OP_INC     = 2'b01,
    OP_CLR     = 2'b10,
    OP_CLR_INC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLR    = 2'd1,
    ST_INC    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  // Bit 1 of the opcode selects a clear phase, bit 0 an increment phase.
  function automatic logic op_has_clr(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_has_inc(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/counter4_pulse_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Searches the request vector starting at the internal
// pointer; when en_i is high and some request is present, the pointer moves
// to winner+1 (mod NREQ) at the next rising edge.
//   clk_i   in   1            clock
//   rst_ni  in   1            synchronous reset, active-low (pointer -> 0)
//   en_i    in   1            grant is being consumed this cycle
//   req_i   in   NREQ         request vector
//   grant_o out  NREQ         one-hot grant (all zero when no request)
//   idx_o   out  $clog2(NREQ) index of the granted requester
//   any_o   out  1            at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // cand_idx[k] is the requester examined at search offset k from the pointer.
  logic [IDX_W-1:0] cand_idx [NREQ];
  logic [NREQ-1:0]  hit;
  logic [NREQ:0]    seen;
  logic [IDX_W-1:0] idx_acc [NREQ+1];

  assign seen[0]    = 1'b0;
  assign idx_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_search
      logic [IDX_W:0] sum;
      logic           first;

      // Wider sum so the modulo-NREQ wrap works for non-power-of-two NREQ.
      assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= NREQ_EXT) ? IDX_W'(sum - NREQ_EXT) : IDX_W'(sum);
      assign hit[gi]      = req_i[cand_idx[gi]];

      // First hit in search order wins; earlier hits mask later ones.
      assign first          = hit[gi] & ~seen[gi];
      assign seen[gi+1]     = seen[gi] | hit[gi];
      assign idx_acc[gi+1]  = idx_acc[gi] | (first ? cand_idx[gi] : '0);
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant_o[gi] = any_o && (idx_o == IDX_W'(gi));
    end
  endgenerate

  assign any_o = |req_i;
  assign idx_o = idx_acc[NREQ];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && any_o) begin
      ptr_d = (idx_o == LAST_IDX) ? '0 : idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/counter4_pulse_sched.sv
// ---------------------------------------------------------------------------
// counter4_pulse_sched
// Shares the en/rst pads of an external 4-bit counter macro among NREQ
// requesters. Requests (clear / increment-by-N) are arbitrated round-robin,
// turned into one-cycle cnt_rst/en pulses, tracked in a shadow count, and the
// macro's count outputs are compared with the shadow after a settle period.
//   GCLK_Pad     in   1            clock, rising edge
//   rst_Pad      in   1            synchronous reset, active-low
//   req_valid    in   NREQ         request pending per requester
//   req_op       in   2*NREQ       opcode per requester, [2i+1:2i]
//   req_len      in   LEN_W*NREQ   increment count per requester
//   req_ready    out  NREQ         one-hot accept pulse
//   en_Pad       out  1            increment pulse to the counter macro
//   cnt_rst_Pad  out  1            clear pulse to the counter macro
//   count_Pad    in   CNT_W        counter macro outputs
//   done         out  1            one-cycle completion pulse
//   done_id      out  $clog2(NREQ) requester of the completed op
//   shadow_count out  CNT_W        expected counter value
//   mismatch     out  1            sticky count_Pad != shadow_count flag
// ---------------------------------------------------------------------------
module counter4_pulse_sched
  import counter4_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int CNT_W      = 4,
  parameter int LEN_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    GCLK_Pad,
  input  logic                    rst_Pad,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [LEN_W*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]         req_ready,
  output logic                    en_Pad,
  output logic                    cnt_rst_Pad,
  input  logic [CNT_W-1:0]        count_Pad,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNT_W-1:0]        shadow_count,
  output logic                    mismatch
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             mismatch_q, mismatch_d;

  logic [OP_W-1:0]  op_arr  [NREQ];
  logic [LEN_W-1:0] len_arr [NREQ];

  logic [NREQ-1:0]  arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;
  logic             accept;
  logic             settle_last;
  op_e              win_op;
  logic [LEN_W-1:0] win_len;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_arr[gi]  = req_op[OP_W*gi +: OP_W];
      assign len_arr[gi] = req_len[LEN_W*gi +: LEN_W];
    end
  endgenerate

  // Grants are only consumed in IDLE, so the pointer only advances on accept.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i   (GCLK_Pad),
    .rst_ni  (rst_Pad),
    .en_i    (accept),
    .req_i   (req_valid),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign accept      = rst_Pad && (state_q == ST_IDLE) && arb_any;
  assign win_op      = op_e'(op_arr[arb_idx]);
  assign win_len     = len_arr[arb_idx];
  assign settle_last = (state_q == ST_SETTLE) && (settle_q == '0);

  // State register
  always_ff @(posedge GCLK_Pad) begin
    if (!rst_Pad) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      rem_q      <= '0;
      id_q       <= '0;
      settle_q   <= SETTLE_LAST;
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rem_d      = rem_q;
    id_d       = id_q;
    shadow_d   = shadow_q;
    mismatch_d = mismatch_q;
    // The settle counter is preloaded while outside SETTLE so entry needs no
    // special case.
    settle_d   = SETTLE_LAST;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = win_op;
          rem_d = win_len;
          id_d  = arb_idx;
          if (op_has_clr(win_op)) begin
            state_d = ST_CLR;
          end else if (op_has_inc(win_op) && (win_len != '0)) begin
            state_d = ST_INC;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_CLR: begin
        shadow_d = '0;
        if (op_has_inc(op_q) && (rem_q != '0)) begin
          state_d = ST_INC;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_INC: begin
        shadow_d = shadow_q + CNT_W'(1);
        rem_d    = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        settle_d = settle_q - SET_W'(1);
        if (settle_q == '0) begin
          mismatch_d = mismatch_q | (count_Pad != shadow_q);
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. Pulses are qualified with rst_Pad so nothing reaches the macro
  // while reset is asserted.
  always_comb begin
    req_ready   = '0;
    en_Pad      = 1'b0;
    cnt_rst_Pad = 1'b0;
    done        = 1'b0;
    done_id     = '0;
    if (rst_Pad) begin
      if (state_q == ST_IDLE) begin
        req_ready = arb_grant;
      end
      en_Pad      = (state_q == ST_INC);
      cnt_rst_Pad = (state_q == ST_CLR);
      done        = settle_last;
      done_id     = settle_last ? id_q : '0;
    end
  end

  assign shadow_count = shadow_q;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_counter4_pulse_sched.sv
module tb_counter4_pulse_sched;

  localparam int NREQ       = 4;
  localparam int SETTLE_CYC = 2;

  logic        GCLK_Pad  = 1'b0;
  logic        rst_Pad   = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op    = '0;
  logic [15:0] req_len   = '0;
  logic [3:0]  req_ready;
  logic        en_Pad;
  logic        cnt_rst_Pad;
  logic [3:0]  count_Pad;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  shadow_count;
  logic        mismatch;

  counter4_pulse_sched #(
    .NREQ(4), .CNT_W(4), .LEN_W(4), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .GCLK_Pad     (GCLK_Pad),
    .rst_Pad      (rst_Pad),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .en_Pad       (en_Pad),
    .cnt_rst_Pad  (cnt_rst_Pad),
    .count_Pad    (count_Pad),
    .done         (done),
    .done_id      (done_id),
    .shadow_count (shadow_count),
    .mismatch     (mismatch)
  );

  always #5 GCLK_Pad = ~GCLK_Pad;

  // Behavioural stand-in for the counter macro, with an optional stuck-at-0 fault.
  logic [3:0] cm    = '0;
  logic       stuck = 1'b0;
  always @(posedge GCLK_Pad) begin
    if (cnt_rst_Pad) cm <= '0;
    else if (en_Pad) cm <= cm + 4'd1;
  end
  assign count_Pad = stuck ? 4'd0 : cm;

  int cyc = 0;
  always @(posedge GCLK_Pad) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operation-level model: one op at a time, described by its accept cycle,
  // whether it has a clear phase, its effective increment count, and the
  // shadow value it started from.
  int m_c   = -1000;
  int m_d   = -1000;
  int m_clr = 0;
  int m_len = 0;
  int m_s0  = 0;
  int m_id  = 0;
  int m_ptr = 0;
  bit m_mism  = 1'b0;
  bit m_valid = 1'b0;

  function automatic int exp_shadow(input int t);
    int base, fe, n;
    base = (m_clr != 0 && t > m_c + 1) ? 0 : m_s0;
    fe   = m_c + 1 + m_clr;
    n    = t - fe;
    if (n < 0) n = 0;
    if (n > m_len) n = m_len;
    return (base + n) % 16;
  endfunction

  always @(negedge GCLK_Pad) begin : compare
    int t, fe, win, idx;
    logic [3:0] e_ready;
    logic [1:0] opv;
    logic [3:0] lenv;
    bit e_en, e_rst, e_done;
    t = cyc;
    if (m_valid) begin
      fe     = m_c + 1 + m_clr;
      e_en   = rst_Pad && t >= fe && t < fe + m_len;
      e_rst  = rst_Pad && m_clr != 0 && t == m_c + 1;
      e_done = rst_Pad && t == m_d;
      e_ready = '0;
      win     = -1;
      if (rst_Pad && t > m_d && req_valid != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[idx[1:0]]) win = idx;
        end
        e_ready = 4'(1 << win);
      end
      check("ready", req_ready, e_ready);
      check("en_Pad", en_Pad, e_en);
      check("cnt_rst_Pad", cnt_rst_Pad, e_rst);
      check("done", done, e_done);
      if (e_done) check("done_id", done_id, m_id);
      check("shadow_count", shadow_count, exp_shadow(t));
      check("mismatch", mismatch, m_mism);
      if (e_done && count_Pad != 4'(exp_shadow(t))) m_mism = 1'b1;
      if (win >= 0) begin
        opv   = 2'(req_op >> (2 * win));
        lenv  = 4'(req_len >> (4 * win));
        m_s0  = exp_shadow(t);
        m_c   = t;
        m_clr = opv[1] ? 1 : 0;
        m_len = opv[0] ? int'(lenv) : 0;
        m_d   = t + m_clr + m_len + SETTLE_CYC;
        m_id  = win;
        m_ptr = (win + 1) % NREQ;
      end
    end
    if (!rst_Pad) begin
      m_valid = 1'b1;
      m_c = -1000; m_d = -1000; m_clr = 0; m_len = 0; m_s0 = 0;
      m_id = 0; m_ptr = 0; m_mism = 1'b0;
    end
  end

  int en_cnt = 0, clr_cnt = 0, overlap = 0;
  always @(negedge GCLK_Pad) begin
    if (en_Pad) en_cnt++;
    if (cnt_rst_Pad) clr_cnt++;
    if (en_Pad && cnt_rst_Pad) overlap++;
  end

  task automatic run_op(input logic [1:0] id, input logic [1:0] op, input logic [3:0] len,
                        output int lat, output int did);
    int acc;
    acc = -1; lat = -1; did = -1;
    @(posedge GCLK_Pad); #1;
    req_valid[id] = 1'b1;
    req_op[{id, 1'b0} +: 2]  = op;
    req_len[{id, 2'b00} +: 4] = len;
    en_cnt = 0; clr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge GCLK_Pad);
      if (req_ready[id]) begin acc = cyc; break; end
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    @(posedge GCLK_Pad); #1;
    req_valid[id] = 1'b0;
    if (acc >= 0) begin
      for (int i = 0; i < 60; i++) begin
        @(negedge GCLK_Pad);
        if (done) begin lat = cyc - acc; did = int'(done_id); break; end
      end
      if (lat < 0) check("done_timeout", 0, 1);
    end
  endtask

  int lat, did, n, r;
  int order[$];
  int exp_order[6] = '{0, 1, 2, 3, 0, 2};

  initial begin
    // Reset with every requester asking: nothing may be granted or pulsed.
    rst_Pad = 1'b0; req_valid = 4'hF;
    @(posedge GCLK_Pad); @(posedge GCLK_Pad);
    @(negedge GCLK_Pad);
    check("rst_ready", req_ready, 0);
    check("rst_en", en_Pad, 0);
    check("rst_clr", cnt_rst_Pad, 0);
    check("rst_done", done, 0);
    check("rst_shadow", shadow_count, 0);
    check("rst_mismatch", mismatch, 0);
    @(posedge GCLK_Pad); #1;
    req_valid = '0; rst_Pad = 1'b1;

    // INC 5 from requester 0: latency 0+5+2.
    run_op(2'd0, 2'b01, 4'd5, lat, did);
    check("inc5_lat", lat, 7);
    check("inc5_id", did, 0);
    check("inc5_pulses", en_cnt, 5);
    check("inc5_shadow", shadow_count, 5);
    @(negedge GCLK_Pad);
    check("inc5_mismatch", mismatch, 0);

    // Bring shadow to 14, then CLR_INC 3 from requester 1: latency 1+3+2.
    run_op(2'd2, 2'b01, 4'd9, lat, did);
    check("to14_shadow", shadow_count, 14);
    run_op(2'd1, 2'b11, 4'd3, lat, did);
    check("clrinc_lat", lat, 6);
    check("clrinc_id", did, 1);
    check("clrinc_rst_pulses", clr_cnt, 1);
    check("clrinc_en_pulses", en_cnt, 3);
    check("clrinc_shadow", shadow_count, 3);

    // Wrap 15 -> 1.
    run_op(2'd2, 2'b01, 4'd12, lat, did);
    check("to15_shadow", shadow_count, 15);
    run_op(2'd3, 2'b01, 4'd2, lat, did);
    check("wrap_shadow", shadow_count, 1);
    @(negedge GCLK_Pad);
    check("wrap_mismatch", mismatch, 0);

    // All four at once (pointer is back at 0), then 0 and 2 again.
    @(posedge GCLK_Pad); #1;
    req_op  = {2'b11, 2'b01, 2'b10, 2'b00};
    req_len = {4'd0, 4'd1, 4'd7, 4'd9};
    req_valid = 4'hF;
    overlap = 0;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge GCLK_Pad);
      if (req_ready != 0) begin
        r = int'(req_ready);
        for (int k = 0; k < 4; k++) if (r[k]) order.push_back(k);
        n++;
        @(posedge GCLK_Pad); #1;
        req_valid = req_valid & ~4'(r);
      end
    end
    check("round1_grants", n, 4);
    req_op  = {2'b00, 2'b01, 2'b00, 2'b01};
    req_len = {4'd0, 4'd2, 4'd0, 4'd2};
    req_valid = 4'b0101;
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge GCLK_Pad);
      if (req_ready != 0) begin
        r = int'(req_ready);
        for (int k = 0; k < 4; k++) if (r[k]) order.push_back(k);
        n++;
        @(posedge GCLK_Pad); #1;
        req_valid = req_valid & ~4'(r);
      end
    end
    check("round2_grants", n, 2);
    repeat (10) @(posedge GCLK_Pad);
    check("order_len", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) check("grant_order", order[i], exp_order[i]);
    check("no_overlap", overlap, 0);
    @(negedge GCLK_Pad);
    check("multi_shadow", shadow_count, 4);
    check("multi_mismatch", mismatch, 0);

    // Stuck-at-0 macro: mismatch sets and stays set.
    @(posedge GCLK_Pad); #1; stuck = 1'b1;
    run_op(2'd2, 2'b01, 4'd1, lat, did);
    @(negedge GCLK_Pad);
    check("fault_mismatch", mismatch, 1);
    run_op(2'd0, 2'b10, 4'd0, lat, did);
    @(negedge GCLK_Pad);
    check("fault_sticky", mismatch, 1);
    @(posedge GCLK_Pad); #1; stuck = 1'b0;

    // Reset in the middle of an INC 10: pulses stop, flags clear.
    @(posedge GCLK_Pad); #1;
    req_op[3:2] = 2'b01; req_len[7:4] = 4'd10; req_valid[1] = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 50 && en_cnt < 3; i++) begin
      @(negedge GCLK_Pad);
      if (req_ready[1]) begin @(posedge GCLK_Pad); #1; req_valid[1] = 1'b0; end
    end
    check("midrst_started", en_cnt, 3);
    @(posedge GCLK_Pad); #1; rst_Pad = 1'b0;
    @(posedge GCLK_Pad); #1; rst_Pad = 1'b1;
    en_cnt = 0;
    repeat (5) @(negedge GCLK_Pad);
    check("midrst_no_pulse", en_cnt, 0);
    check("midrst_mismatch", mismatch, 0);
    check("midrst_shadow", shadow_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
